seq_table_loader: RTL

// - Producer side of the sequencer table-write interface. Pulls a sequencer table from an upstream

---
 rtl/seq_table_pkg.sv | 17 +
 rtl/wstb_pacer.sv | 44 ++++
 rtl/seq_table_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_table_pkg.sv
// Shared constants and types for the sequencer table loader.
package seq_table_pkg;

    localparam int unsigned WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_ABORT = 2'd2;

endpackage

// File: rtl/wstb_pacer.sv
// Enforces a minimum idle gap between accepted words; allow_nxt says whether the next cycle may accept.
// Latency: combinational look-ahead of the registered gap counter. Backpressure: none, advisory only.
module wstb_pacer #(
    parameter int unsigned GAP = 0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear,
    input  logic accept,
    output logic allow_nxt
);

    if (GAP > 15) begin : g_gap_check
        $error("wstb_pacer: GAP must be in 0..15");
    end

    localparam logic [3:0] GAP_W = 4'(GAP);

    logic [3:0] gap_q;
    logic [3:0] gap_d;

    // Clearing preloads the saturated value so the first word of a load is never delayed.
    always_comb begin
        gap_d = gap_q;
        if (clear) begin
            gap_d = GAP_W;
        end else if (accept) begin
            gap_d = '0;
        end else if (gap_q != GAP_W) begin
            gap_d = gap_q + 4'd1;
        end
    end

    assign allow_nxt = (gap_d == GAP_W);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/seq_table_loader.sv
// Pulls a sequencer table from a valid/ready word stream and drives the sequencer table-write port.
// Latency: TABLE_START 1 cycle after load_start_i; each accepted word strobes 1 cycle after accept.
// Backpressure: s_ready_o is paced by wstb_pacer and dropped after the final word; upstream may stall.
module seq_table_loader #(
    parameter int unsigned MAX_LINES      = 1024,
    parameter int unsigned WORDS_PER_LINE = seq_table_pkg::WORDS_PER_LINE,
    parameter int unsigned WSTB_GAP       = 0
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        load_start_i,
    input  logic [15:0] load_lines_i,
    input  logic        abort_i,
    input  logic [31:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic        TABLE_START,
    output logic [31:0] TABLE_DATA,
    output logic        TABLE_WSTB,
    output logic [15:0] TABLE_LENGTH,
    output logic        TABLE_LENGTH_WSTB,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] words_o
);
    import seq_table_pkg::*;

    if (MAX_LINES * WORDS_PER_LINE > 65535) begin : g_len_check
        $error("seq_table_loader: MAX_LINES*WORDS_PER_LINE exceeds 16 bits");
    end

    state_t      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] words_q, words_d;
    logic [31:0] data_q, data_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  err_q, err_d;
    logic        ready_q, ready_d;
    logic        start_q, start_d;
    logic        wstb_q, wstb_d;
    logic        len_wstb_q, len_wstb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic        abort;
    logic        lines_ok;
    logic        allow_nxt;

    assign accept   = ready_q & s_valid_i;
    assign abort    = abort_i & (state_q != ST_IDLE);
    assign lines_ok = (load_lines_i != 16'd0) && (32'(load_lines_i) <= MAX_LINES);

    wstb_pacer #(
        .GAP (WSTB_GAP)
    ) u_pacer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear     (state_q == ST_START),
        .accept    (accept),
        .allow_nxt (allow_nxt)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        words_d    = words_q;
        data_d     = data_q;
        len_d      = len_q;
        err_d      = err_q;
        start_d    = 1'b0;
        wstb_d     = 1'b0;
        len_wstb_d = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    if (lines_ok) begin
                        target_d = 16'(load_lines_i * 16'(WORDS_PER_LINE));
                        words_d  = '0;
                        err_d    = ERR_NONE;
                        start_d  = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        err_d = ERR_LEN;
                    end
                end
            end
            ST_START: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // words_q equals the accept count: it lags each accept by exactly the strobe delay.
                if (accept) begin
                    data_d  = s_data_i;
                    wstb_d  = 1'b1;
                    words_d = words_q + 16'd1;
                    if (words_q + 16'd1 == target_q) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                len_d      = target_q;
                len_wstb_d = 1'b1;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

        // Abort beats everything, including a coincident final accept or the commit itself.
        if (abort) begin
            state_d    = ST_IDLE;
            err_d      = ERR_ABORT;
            data_d     = data_q;
            words_d    = words_q;
            len_d      = len_q;
            start_d    = 1'b0;
            wstb_d     = 1'b0;
            len_wstb_d = 1'b0;
            done_d     = 1'b0;
        end

        busy_d  = (state_d != ST_IDLE) || ((state_q == ST_COMMIT) && !abort);
        ready_d = (state_d == ST_STREAM) && allow_nxt;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            words_q    <= '0;
            data_q     <= '0;
            len_q      <= '0;
            err_q      <= ERR_NONE;
            ready_q    <= 1'b0;
            start_q    <= 1'b0;
            wstb_q     <= 1'b0;
            len_wstb_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            words_q    <= words_d;
            data_q     <= data_d;
            len_q      <= len_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            start_q    <= start_d;
            wstb_q     <= wstb_d;
            len_wstb_q <= len_wstb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_ready_o         = ready_q;
    assign TABLE_START       = start_q;
    assign TABLE_DATA        = data_q;
    assign TABLE_WSTB        = wstb_q;
    assign TABLE_LENGTH      = len_q;
    assign TABLE_LENGTH_WSTB = len_wstb_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_code_o        = err_q;
    assign words_o           = words_q;

endmodule
